// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Contents:
//   state_t      - control FSM states
//   op_class_t   - dispatch class of an opcode
//   OPC_*        - instruction opcodes, 8-bit values
//   ALU_*        - ALU operation codes driven on alu_op
//   PC_SEL_*     - PC source select encodings
//   FAULT_*      - fault_code encodings
//   op_class / alu_code / branch_taken - decode helpers
package uc_pkg;

  typedef enum logic [3:0] {
    ST_START     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC_ALU  = 4'd3,
    ST_EXEC_MOVA = 4'd4,
    ST_EXEC_MOVB = 4'd5,
    ST_BRANCH    = 4'd6,
    ST_CALL      = 4'd7,
    ST_RET       = 4'd8,
    ST_HALT      = 4'd9,
    ST_TRAP      = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MOVA    = 3'd1,
    CLS_MOVB    = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_CALL    = 3'd4,
    CLS_RET     = 3'd5,
    CLS_HALT    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_t;

  // Instruction opcodes
  localparam logic [7:0] OPC_ADD  = 8'h01;
  localparam logic [7:0] OPC_SUB  = 8'h02;
  localparam logic [7:0] OPC_MUL  = 8'h03;
  localparam logic [7:0] OPC_DIV  = 8'h04;
  localparam logic [7:0] OPC_MOD  = 8'h05;
  localparam logic [7:0] OPC_CMP  = 8'h1F;
  localparam logic [7:0] OPC_SHL  = 8'h3C;
  localparam logic [7:0] OPC_SHR  = 8'h3D;
  localparam logic [7:0] OPC_AND  = 8'h75;
  localparam logic [7:0] OPC_OR   = 8'h76;
  localparam logic [7:0] OPC_XOR  = 8'h77;
  localparam logic [7:0] OPC_NOT  = 8'h78;
  localparam logic [7:0] OPC_NAND = 8'h79;
  localparam logic [7:0] OPC_NOR  = 8'h7A;
  localparam logic [7:0] OPC_XNOR = 8'h7B;
  localparam logic [7:0] OPC_MOVA = 8'h80;
  localparam logic [7:0] OPC_JMP  = 8'h81;
  localparam logic [7:0] OPC_CALL = 8'h82;
  localparam logic [7:0] OPC_RET  = 8'h83;
  localparam logic [7:0] OPC_GOTO = 8'h84;
  localparam logic [7:0] OPC_JZ   = 8'h85;
  localparam logic [7:0] OPC_JNZ  = 8'h87;
  localparam logic [7:0] OPC_MOVB = 8'hC0;
  localparam logic [7:0] OPC_HALT = 8'hFF;

  // ALU operation codes
  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SUB  = 8'h02;
  localparam logic [7:0] ALU_MUL  = 8'h03;
  localparam logic [7:0] ALU_DIV  = 8'h04;
  localparam logic [7:0] ALU_MOD  = 8'h05;
  localparam logic [7:0] ALU_AND  = 8'h06;
  localparam logic [7:0] ALU_OR   = 8'h07;
  localparam logic [7:0] ALU_XOR  = 8'h08;
  localparam logic [7:0] ALU_NAND = 8'h09;
  localparam logic [7:0] ALU_NOR  = 8'h0A;
  localparam logic [7:0] ALU_XNOR = 8'h0B;
  localparam logic [7:0] ALU_CMP  = 8'h0C;
  localparam logic [7:0] ALU_SHL  = 8'h0D;
  localparam logic [7:0] ALU_SHR  = 8'h0E;
  localparam logic [7:0] ALU_NOT  = 8'h0F;

  // PC source select
  localparam logic [1:0] PC_SEL_INC    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_RET    = 2'd2;

  // Fault codes
  localparam logic [1:0] FAULT_NONE      = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL   = 2'd1;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'd2;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'd3;

  function automatic op_class_t op_class(input logic [7:0] op);
    op_class_t cls;
    case (op)
      OPC_ADD, OPC_SUB, OPC_MUL, OPC_DIV, OPC_MOD,
      OPC_AND, OPC_OR, OPC_XOR, OPC_NOT, OPC_NAND, OPC_NOR, OPC_XNOR,
      OPC_SHL, OPC_SHR, OPC_CMP:        cls = CLS_ALU;
      OPC_MOVA:                         cls = CLS_MOVA;
      OPC_MOVB:                         cls = CLS_MOVB;
      OPC_JMP, OPC_GOTO, OPC_JZ, OPC_JNZ: cls = CLS_BRANCH;
      OPC_CALL:                         cls = CLS_CALL;
      OPC_RET:                          cls = CLS_RET;
      OPC_HALT:                         cls = CLS_HALT;
      default:                          cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Instruction opcode to ALU operation; anything non-ALU yields NOP.
  function automatic logic [7:0] alu_code(input logic [7:0] op);
    logic [7:0] code;
    case (op)
      OPC_ADD:  code = ALU_ADD;
      OPC_SUB:  code = ALU_SUB;
      OPC_MUL:  code = ALU_MUL;
      OPC_DIV:  code = ALU_DIV;
      OPC_MOD:  code = ALU_MOD;
      OPC_AND:  code = ALU_AND;
      OPC_OR:   code = ALU_OR;
      OPC_XOR:  code = ALU_XOR;
      OPC_NOT:  code = ALU_NOT;
      OPC_NAND: code = ALU_NAND;
      OPC_NOR:  code = ALU_NOR;
      OPC_XNOR: code = ALU_XNOR;
      OPC_CMP:  code = ALU_CMP;
      OPC_SHL:  code = ALU_SHL;
      OPC_SHR:  code = ALU_SHR;
      default:  code = ALU_NOP;
    endcase
    return code;
  endfunction

  function automatic logic branch_taken(input logic [7:0] op, input logic zf);
    logic taken;
    case (op)
      OPC_JMP, OPC_GOTO: taken = 1'b1;
      OPC_JZ:            taken = zf;
      OPC_JNZ:           taken = ~zf;
      default:           taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for CALL/RET.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset (empties)
//   push, pop     - push din / discard top; ignored when full / empty
//   din           - address to push
//   top           - current top entry, 0 when empty
//   full, empty   - occupancy flags
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  // One extra pointer bit distinguishes full (ptr == DEPTH) from empty.
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic [PTR_W-1:0] ptr_r;
  logic [W-1:0]     mem_r [DEPTH];
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] top_idx_s;

  // With DEPTH a power of two the low pointer bits wrap cleanly, so
  // ptr == DEPTH maps top to entry DEPTH-1.
  assign wr_idx_s  = ptr_r[IDX_W-1:0];
  assign top_idx_s = wr_idx_s - IDX_W'(1);
  assign full      = (ptr_r == PTR_W'(DEPTH));
  assign empty     = (ptr_r == '0);
  assign top       = empty ? '0 : mem_r[top_idx_s];

  // Pointer and storage update; push wins if a caller ever raises both.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !full) begin
      mem_r[wr_idx_s] <= din;
      ptr_r           <= ptr_r + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr_r <= ptr_r - PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/uc_multicycle.sv
// Multi-cycle control unit: fetch with memory-ready handshake, decode,
// ALU/MOV execute, resolved branches, CALL/RET via a return stack, HALT,
// and a sticky trap on illegal opcodes or stack faults.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   ir                - current instruction opcode
//   mem_ready         - instruction memory data valid
//   zero_flag         - ALU zero flag for conditional branches
//   pc_in             - next sequential address (pushed by CALL)
//   mem_req           - fetch request
//   ir_load, reg_load_a/b/c, pc_load - datapath load enables
//   pc_sel            - 0 increment, 1 branch target, 2 ret_addr
//   ret_addr          - top of return stack (0 when empty)
//   alu_op            - ALU operation code
//   halted, fault     - HALT executed / trap taken
//   fault_code        - 0 none, 1 illegal, 2 overflow, 3 underflow
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int OP_W        = 8,
  parameter int ALU_OP_W    = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OP_W-1:0]     ir,
  input  logic                mem_ready,
  input  logic                zero_flag,
  input  logic [ADDR_W-1:0]   pc_in,
  output logic                mem_req,
  output logic                ir_load,
  output logic                reg_load_a,
  output logic                reg_load_b,
  output logic                reg_load_c,
  output logic                pc_load,
  output logic [1:0]          pc_sel,
  output logic [ADDR_W-1:0]   ret_addr,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_code
);

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  op_r;
  logic [1:0]  fault_code_r;
  logic [1:0]  fault_code_next_s;
  logic [7:0]  ir_low_s;
  logic        ir_upper_zero_s;
  op_class_t   ir_class_s;

  logic                mem_req_s;
  logic                ir_load_s;
  logic                reg_load_a_s;
  logic                reg_load_b_s;
  logic                reg_load_c_s;
  logic                pc_load_s;
  logic [1:0]          pc_sel_s;
  logic [ALU_OP_W-1:0] alu_op_s;
  logic                push_s;
  logic                pop_s;

  logic [ADDR_W-1:0]   stack_top_s;
  logic                stack_full_s;
  logic                stack_empty_s;

  // Opcodes are 8-bit values zero-extended to OP_W: any set bit above
  // bit 7 makes the instruction illegal.
  assign ir_low_s        = ir[7:0];
  assign ir_upper_zero_s = ((ir >> 8) == '0);
  assign ir_class_s      = ir_upper_zero_s ? op_class(ir_low_s) : CLS_ILLEGAL;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pc_in),
    .top   (stack_top_s),
    .full  (stack_full_s),
    .empty (stack_empty_s)
  );

  // State, latched opcode and sticky fault code.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_START;
      op_r         <= 8'h00;
      fault_code_r <= FAULT_NONE;
    end else begin
      state_r      <= next_state_s;
      // Execute states read this copy so late ir changes are harmless.
      op_r         <= (state_r == ST_DECODE) ? ir_low_s : op_r;
      fault_code_r <= fault_code_next_s;
    end
  end

  // Next-state logic and raw (pre-reset-gating) control outputs.
  always_comb begin
    next_state_s      = state_r;
    fault_code_next_s = fault_code_r;
    mem_req_s         = 1'b0;
    ir_load_s         = 1'b0;
    reg_load_a_s      = 1'b0;
    reg_load_b_s      = 1'b0;
    reg_load_c_s      = 1'b0;
    pc_load_s         = 1'b0;
    pc_sel_s          = PC_SEL_INC;
    alu_op_s          = '0;
    push_s            = 1'b0;
    pop_s             = 1'b0;

    case (state_r)
      ST_START: begin
        next_state_s = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_load_s    = 1'b1;
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end

      ST_DECODE: begin
        reg_load_a_s = 1'b1;
        reg_load_b_s = 1'b1;
        case (ir_class_s)
          CLS_ALU:    next_state_s = ST_EXEC_ALU;
          CLS_MOVA:   next_state_s = ST_EXEC_MOVA;
          CLS_MOVB:   next_state_s = ST_EXEC_MOVB;
          CLS_BRANCH: next_state_s = ST_BRANCH;
          CLS_CALL:   next_state_s = ST_CALL;
          CLS_RET:    next_state_s = ST_RET;
          CLS_HALT:   next_state_s = ST_HALT;
          default: begin
            next_state_s      = ST_TRAP;
            fault_code_next_s = FAULT_ILLEGAL;
          end
        endcase
      end

      ST_EXEC_ALU: begin
        reg_load_c_s = 1'b1;
        pc_load_s    = 1'b1;
        alu_op_s     = ALU_OP_W'(alu_code(op_r));
        next_state_s = ST_FETCH;
      end

      ST_EXEC_MOVA: begin
        reg_load_a_s = 1'b1;
        pc_load_s    = 1'b1;
        next_state_s = ST_FETCH;
      end

      ST_EXEC_MOVB: begin
        reg_load_b_s = 1'b1;
        pc_load_s    = 1'b1;
        next_state_s = ST_FETCH;
      end

      ST_BRANCH: begin
        pc_load_s    = 1'b1;
        pc_sel_s     = branch_taken(op_r, zero_flag) ? PC_SEL_BRANCH : PC_SEL_INC;
        next_state_s = ST_FETCH;
      end

      ST_CALL: begin
        if (!stack_full_s) begin
          push_s       = 1'b1;
          pc_load_s    = 1'b1;
          pc_sel_s     = PC_SEL_BRANCH;
          next_state_s = ST_FETCH;
        end else begin
          next_state_s      = ST_TRAP;
          fault_code_next_s = FAULT_OVERFLOW;
        end
      end

      ST_RET: begin
        if (!stack_empty_s) begin
          pop_s        = 1'b1;
          pc_load_s    = 1'b1;
          pc_sel_s     = PC_SEL_RET;
          next_state_s = ST_FETCH;
        end else begin
          next_state_s      = ST_TRAP;
          fault_code_next_s = FAULT_UNDERFLOW;
        end
      end

      ST_HALT: begin
        next_state_s = ST_HALT;
      end

      ST_TRAP: begin
        next_state_s = ST_TRAP;
      end

      default: begin
        next_state_s = ST_START;
      end
    endcase
  end

  // Reset overrides everything combinationally, so a reset landing in
  // the middle of a fetch or execute cycle produces no datapath load.
  assign mem_req    = mem_req_s & ~reset;
  assign ir_load    = ir_load_s & ~reset;
  assign reg_load_a = reg_load_a_s & ~reset;
  assign reg_load_b = reg_load_b_s & ~reset;
  assign reg_load_c = reg_load_c_s & ~reset;
  assign pc_load    = pc_load_s & ~reset;
  assign pc_sel     = reset ? PC_SEL_INC : pc_sel_s;
  assign alu_op     = reset ? '0 : alu_op_s;
  assign ret_addr   = reset ? '0 : stack_top_s;
  assign halted     = (state_r == ST_HALT) & ~reset;
  assign fault      = (state_r == ST_TRAP) & ~reset;
  assign fault_code = reset ? FAULT_NONE : fault_code_r;

endmodule

// File: tb/tb_uc_multicycle.sv
// Self-checking bench for uc_multicycle: per-cycle expected output
// vectors are queued as stimulus is applied and compared on the
// falling clock edge.
module tb_uc_multicycle;

  typedef struct packed {
    logic       mem_req;
    logic       ir_load;
    logic       rla;
    logic       rlb;
    logic       rlc;
    logic       pc_load;
    logic [1:0] pc_sel;
    logic [7:0] ret_addr;
    logic [7:0] alu_op;
    logic       halted;
    logic       fault;
    logic [1:0] fault_code;
  } out_t;

  typedef struct {
    logic [7:0] op;
    logic       zf;
    logic [7:0] alu;
    logic       rla;
    logic       rlb;
    logic       rlc;
    logic [1:0] sel;
  } vec_t;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] ir        = 8'h00;
  logic       mem_ready = 1'b0;
  logic       zero_flag = 1'b0;
  logic [7:0] pc_in     = 8'h00;

  logic       mem_req, ir_load, reg_load_a, reg_load_b, reg_load_c, pc_load;
  logic [1:0] pc_sel;
  logic [7:0] ret_addr;
  logic [7:0] alu_op;
  logic       halted, fault;
  logic [1:0] fault_code;

  uc_multicycle #(
    .OP_W(8), .ALU_OP_W(8), .ADDR_W(8), .STACK_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .ir(ir), .mem_ready(mem_ready),
    .zero_flag(zero_flag), .pc_in(pc_in), .mem_req(mem_req),
    .ir_load(ir_load), .reg_load_a(reg_load_a), .reg_load_b(reg_load_b),
    .reg_load_c(reg_load_c), .pc_load(pc_load), .pc_sel(pc_sel),
    .ret_addr(ret_addr), .alu_op(alu_op), .halted(halted), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  out_t act;
  assign act = {mem_req, ir_load, reg_load_a, reg_load_b, reg_load_c, pc_load,
                pc_sel, ret_addr, alu_op, halted, fault, fault_code};

  out_t       exp_q[$];
  string      name_q[$];
  logic [7:0] model_stk[$];
  int         total = 0;
  int         bad   = 0;
  out_t       sb_e;
  string      sb_n;
  vec_t       vecs[23];

  // Scoreboard: compare the oldest expectation mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      sb_e = exp_q.pop_front();
      sb_n = name_q.pop_front();
      total++;
      if (act !== sb_e) begin
        bad++;
        $display("FAIL %s: got=%h want=%h", sb_n, act, sb_e);
      end
    end
  end

  function automatic out_t base();
    out_t o;
    o = '0;
    o.ret_addr = (model_stk.size() == 0) ? 8'h00 : model_stk[$];
    return o;
  endfunction

  function automatic vec_t mkv(input logic [7:0] op, input logic zf,
                               input logic [7:0] alu, input logic rla,
                               input logic rlb, input logic rlc,
                               input logic [1:0] sel);
    vec_t v;
    v.op = op; v.zf = zf; v.alu = alu; v.rla = rla; v.rlb = rlb;
    v.rlc = rlc; v.sel = sel;
    return v;
  endfunction

  task automatic check_now(input string nm, input out_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, e);
    end
  endtask

  task automatic cyc(input string nm, input out_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [7:0] op, input int waits, input string nm);
    out_t e;
    ir = op;
    mem_ready = 1'b0;
    for (int k = 0; k < waits; k++) begin
      e = base(); e.mem_req = 1'b1;
      cyc({nm, "_wait"}, e);
    end
    if (waits > 0) begin
      e = base(); e.mem_req = 1'b1;
      check_now({nm, "_wait_expired"}, e);
    end
    mem_ready = 1'b1;
    e = base(); e.mem_req = 1'b1; e.ir_load = 1'b1;
    cyc({nm, "_fetch"}, e);
  endtask

  // After decode the ir bus is scrambled: execute must use the latched op.
  task automatic decode(input string nm);
    out_t e;
    e = base(); e.rla = 1'b1; e.rlb = 1'b1;
    cyc({nm, "_decode"}, e);
    ir = 8'h55;
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    cyc({nm, "_rst"}, out_t'(0));
    model_stk.delete();
    reset = 1'b0;
    cyc({nm, "_start"}, out_t'(0));
  endtask

  task automatic call(input logic [7:0] addr, input string nm);
    out_t e;
    fetch(8'h82, 0, nm);
    decode(nm);
    pc_in = addr;
    e = base(); e.pc_load = 1'b1; e.pc_sel = 2'd1;
    cyc({nm, "_exec"}, e);
    model_stk.push_back(addr);
  endtask

  task automatic ret_ok(input string nm);
    out_t e;
    fetch(8'h83, 0, nm);
    decode(nm);
    e = base(); e.pc_load = 1'b1; e.pc_sel = 2'd2;
    cyc({nm, "_exec"}, e);
    void'(model_stk.pop_back());
  endtask

  task automatic trap_cycles(input logic [1:0] code, input string nm);
    out_t e;
    for (int k = 0; k < 2; k++) begin
      e = base(); e.fault = 1'b1; e.fault_code = code;
      cyc({nm, "_trap"}, e);
    end
  endtask

  initial begin
    out_t e;
    vecs[0]  = mkv(8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[1]  = mkv(8'h02, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[2]  = mkv(8'h03, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[3]  = mkv(8'h04, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[4]  = mkv(8'h05, 1'b0, 8'h05, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[5]  = mkv(8'h75, 1'b0, 8'h06, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[6]  = mkv(8'h76, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[7]  = mkv(8'h77, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[8]  = mkv(8'h78, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[9]  = mkv(8'h79, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[10] = mkv(8'h7A, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[11] = mkv(8'h7B, 1'b0, 8'h0B, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[12] = mkv(8'h1F, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[13] = mkv(8'h3C, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[14] = mkv(8'h3D, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[15] = mkv(8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
    vecs[16] = mkv(8'hC0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
    vecs[17] = mkv(8'h81, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
    vecs[18] = mkv(8'h84, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
    vecs[19] = mkv(8'h85, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
    vecs[20] = mkv(8'h85, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    vecs[21] = mkv(8'h87, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
    vecs[22] = mkv(8'h87, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);

    @(posedge clock);
    #1;
    check_now("reset_state", out_t'(0));
    cyc("reset0", out_t'(0));
    cyc("reset1", out_t'(0));
    reset = 1'b0;
    cyc("start0", out_t'(0));

    // Table: every execute-class opcode; vector 1 waits 3 cycles for memory.
    for (int i = 0; i < 23; i++) begin
      zero_flag = ~vecs[i].zf;
      fetch(vecs[i].op, (i == 1) ? 3 : (i % 2), $sformatf("v%0d", i));
      decode($sformatf("v%0d", i));
      zero_flag = vecs[i].zf;
      e = base();
      e.pc_load = 1'b1;
      e.pc_sel  = vecs[i].sel;
      e.alu_op  = vecs[i].alu;
      e.rla     = vecs[i].rla;
      e.rlb     = vecs[i].rlb;
      e.rlc     = vecs[i].rlc;
      cyc($sformatf("v%0d_exec", i), e);
    end

    // Nested CALL/RET, then RET on an empty stack.
    call(8'h10, "call1");
    call(8'h20, "call2");
    ret_ok("ret1");
    ret_ok("ret2");
    fetch(8'h83, 0, "ret3");
    decode("ret3");
    cyc("ret3_exec", base());
    trap_cycles(2'd3, "ret3");
    do_reset("rst_a");

    // Fill the stack, then overflow on the fifth CALL.
    for (int i = 0; i < 4; i++) begin
      call(8'h31 + 8'(i), $sformatf("fill%0d", i));
    end
    fetch(8'h82, 0, "call5");
    decode("call5");
    pc_in = 8'h35;
    cyc("call5_exec", base());
    trap_cycles(2'd2, "call5");
    do_reset("rst_b");

    // Illegal opcode.
    fetch(8'h55, 0, "ill");
    decode("ill");
    trap_cycles(2'd1, "ill");
    do_reset("rst_c");

    // HALT holds with memory ready and no fetch request.
    fetch(8'hFF, 0, "halt");
    decode("halt");
    for (int k = 0; k < 12; k++) begin
      e = base(); e.halted = 1'b1;
      cyc("halt_hold", e);
    end
    do_reset("rst_d");

    // Reset landing in the ALU execute cycle suppresses the load.
    fetch(8'h01, 0, "rexec");
    decode("rexec");
    reset = 1'b1;
    cyc("rexec_exec", out_t'(0));
    model_stk.delete();
    reset = 1'b0;
    cyc("rexec_start", out_t'(0));
    fetch(8'h02, 0, "post");
    decode("post");
    e = base(); e.pc_load = 1'b1; e.rlc = 1'b1; e.alu_op = 8'h02;
    cyc("post_exec", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
